// File: rtl/uart_tx_if.sv
// Word handshake into the UART transmitter: source drives tx_data/tx_valid, transmitter returns tx_ready.
// Transfer on tx_valid && tx_ready at a clock edge; the source holds the word while tx_ready is low.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, STOP_BITS stops; tx is a flop, start bit 1 cycle after accept.
// Backpressure: tx_ready only in IDLE, so a word offered mid-frame stays pending until the frame completes.
module uart_tx #(
    parameter int SYS_CLK_FREQ = 1000000,
    parameter int BAUD_RATE    = 9600,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      sreset_n,
    uart_tx_if.slave  s_if,
    output logic      tx,
    output logic      busy,
    output logic      frame_done
);
    localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (s_if.tx_valid) begin
                    shift_d = s_if.tx_data;
                    par_d   = (PARITY == 2) ? ~^s_if.tx_data : ^s_if.tx_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        // bit counter is reused to count stop bits
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the state being entered so tx changes on the same edge as the state
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!sreset_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s_if.tx_ready = (state_q == S_IDLE);
    assign tx            = tx_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (defaults; even parity + 2 stops; odd parity, 9 bits, 4 clk/bit).
module tb_uart_tx;
    logic clk;
    logic sreset_n;
    logic tx0, busy0, done0;
    logic tx1, busy1, done1;
    logic tx2, busy2, done2;
    int   errors;
    int   checks;

    uart_tx_if #(.DATA_WIDTH(8)) if0 ();
    uart_tx_if #(.DATA_WIDTH(8)) if1 ();
    uart_tx_if #(.DATA_WIDTH(9)) if2 ();

    uart_tx dut0 (
        .clk(clk), .sreset_n(sreset_n), .s_if(if0),
        .tx(tx0), .busy(busy0), .frame_done(done0)
    );

    uart_tx #(.PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .sreset_n(sreset_n), .s_if(if1),
        .tx(tx1), .busy(busy1), .frame_done(done1)
    );

    uart_tx #(.SYS_CLK_FREQ(40000), .BAUD_RATE(9600), .DATA_WIDTH(9), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .sreset_n(sreset_n), .s_if(if2),
        .tx(tx2), .busy(busy2), .frame_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_tx(input int w);
        case (w)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic get_rdy(input int w);
        case (w)
            0:       return if0.tx_ready;
            1:       return if1.tx_ready;
            default: return if2.tx_ready;
        endcase
    endfunction

    task automatic set_in(input int w, input logic vld, input logic [8:0] dat);
        case (w)
            0: begin if0.tx_valid = vld; if0.tx_data = dat[7:0]; end
            1: begin if1.tx_valid = vld; if1.tx_data = dat[7:0]; end
            default: begin if2.tx_valid = vld; if2.tx_data = dat; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after the accepting edge; walks every cycle of the frame, then the frame_done cycle.
    task automatic check_frame(input int w, input logic [8:0] data, input int nbits,
                               input int par, input int stops, input int cpb, input string tag);
        logic exp_bits[$];
        logic p;
        logic bad_tx;
        logic bad_ctl;
        p = 1'b0;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            exp_bits.push_back(data[i]);
            p = p ^ data[i];
        end
        if (par == 1) exp_bits.push_back(p);
        if (par == 2) exp_bits.push_back(~p);
        for (int i = 0; i < stops; i++) exp_bits.push_back(1'b1);
        for (int b = 0; b < exp_bits.size(); b++) begin
            bad_tx  = 1'b0;
            bad_ctl = 1'b0;
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                if (get_tx(w) !== exp_bits[b]) bad_tx = 1'b1;
                if (get_done(w) !== 1'b0 || get_rdy(w) !== 1'b0 || get_busy(w) !== 1'b1) bad_ctl = 1'b1;
            end
            chk($sformatf("%s bit%0d tx wrong in period", tag, b), {31'd0, bad_tx}, 32'd0);
            chk($sformatf("%s bit%0d ctl wrong in period", tag, b), {31'd0, bad_ctl}, 32'd0);
        end
        @(negedge clk);
        chk({tag, " frame_done"}, {31'd0, get_done(w)}, 32'd1);
        chk({tag, " ready_back"}, {31'd0, get_rdy(w)}, 32'd1);
        chk({tag, " busy_clear"}, {31'd0, get_busy(w)}, 32'd0);
        chk({tag, " tx_idle"},    {31'd0, get_tx(w)},   32'd1);
    endtask

    // Offer a word at a negedge, confirm it is accepted on the next edge, then drop valid.
    task automatic send(input int w, input logic [8:0] data);
        @(negedge clk);
        set_in(w, 1'b1, data);
        chk("ready_before_send", {31'd0, get_rdy(w)}, 32'd1);
        @(posedge clk);
        #1;
        set_in(w, 1'b0, 9'h1AA);
    endtask

    initial begin
        logic       bad;
        logic [8:0] rnd;
        errors   = 0;
        checks   = 0;
        sreset_n = 1'b0;
        set_in(0, 1'b0, 9'h000);
        set_in(1, 1'b0, 9'h000);
        set_in(2, 1'b0, 9'h000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("reset tx%0d", w),    {31'd0, get_tx(w)},   32'd1);
            chk($sformatf("reset rdy%0d", w),   {31'd0, get_rdy(w)},  32'd1);
            chk($sformatf("reset busy%0d", w),  {31'd0, get_busy(w)}, 32'd0);
            chk($sformatf("reset done%0d", w),  {31'd0, get_done(w)}, 32'd0);
        end
        sreset_n = 1'b1;

        // 0xA5 at 104 clk/bit: 0,1,0,1,0,0,1,0,1,1
        send(0, 9'h0A5);
        check_frame(0, 9'h0A5, 8, 0, 1, 104, "a5");
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done0}, 32'd0);

        // 0x07 even parity -> parity bit 1, two stop bits (208 cycles)
        send(1, 9'h007);
        check_frame(1, 9'h007, 8, 1, 2, 104, "even07");

        // 0x07 odd parity -> parity bit 0
        send(2, 9'h007);
        check_frame(2, 9'h007, 9, 2, 1, 4, "odd07");

        // back-to-back: valid held, data changed after acceptance must not affect frame 1
        @(negedge clk);
        set_in(0, 1'b1, 9'h000);
        @(posedge clk);
        #1;
        set_in(0, 1'b1, 9'h0FF);
        check_frame(0, 9'h000, 8, 0, 1, 104, "b2b00");
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 9'h0FF);
        check_frame(0, 9'h0FF, 8, 0, 1, 104, "b2bFF");

        // a word offered while busy is ignored
        send(0, 9'h05A);
        fork
            check_frame(0, 9'h05A, 8, 0, 1, 104, "busy5a");
            begin
                repeat (300) @(negedge clk);
                set_in(0, 1'b1, 9'h03C);
                @(negedge clk);
                set_in(0, 1'b0, 9'h03C);
            end
        join
        bad = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
        end
        chk("no_second_frame", {31'd0, bad}, 32'd0);

        // reset during DATA bit 3 of 0xA5 (bit 3 = 0)
        send(0, 9'h0A5);
        repeat (104 * 4 + 50) @(negedge clk);
        chk("in_bit3_tx", {31'd0, tx0}, 32'd0);
        sreset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_tx",   {31'd0, tx0},           32'd1);
        chk("rst_mid_busy", {31'd0, busy0},         32'd0);
        chk("rst_mid_rdy",  {31'd0, if0.tx_ready},  32'd1);
        @(negedge clk);
        sreset_n = 1'b1;
        send(0, 9'h055);
        check_frame(0, 9'h055, 8, 0, 1, 104, "after_rst55");

        // random words on the fast odd-parity instance
        for (int i = 0; i < 12; i++) begin
            rnd = 9'($urandom_range(0, 511));
            send(2, rnd);
            check_frame(2, rnd, 9, 2, 1, 4, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter. Serialises one parallel word per valid/ready handshake into a standard asynchronous frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, STOP_BITS stop bits. It sits between the system-side data source and the serial line, clocked from the system clock with an internal baud-tick divider. It pairs with the team's UART receiver at the same baud rate and data width.

Parameters:
SYS_CLK_FREQ, 1000000, system clock frequency in Hz
BAUD_RATE, 9600, serial bit rate in bit/s; CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE (integer divide), must be >= 2
DATA_WIDTH, 8, data bits per frame, range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock; all logic on the rising edge
sreset_n  input  1  synchronous active-low reset
tx_data  input  DATA_WIDTH  word to transmit
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block accepts a word this cycle
tx  output  1  serial line out, idle high
busy  output  1  frame in progress
frame_done  output  1  single-cycle pulse when the last stop bit completes

Behaviour:
- Reset (sreset_n low at a clk edge): state IDLE, tx=1, tx_ready=1, busy=0, frame_done=0, baud counter=0, bit counter=0, shift register=0. Reset mid-frame aborts the frame immediately. tx returns high on the next edge. No partial stop bit.
- Handshake: transfer happens when tx_valid && tx_ready at a clk edge. tx_ready = (state==IDLE). It is registered low from the edge after acceptance until the frame ends. tx_data is captured on the transfer edge only. Later changes to tx_data are ignored.
- Baud timer: a counter from 0 to CLKS_PER_BIT-1 runs only outside IDLE. It restarts at 0 on every state entry. Every bit period is exactly CLKS_PER_BIT clk cycles.
- States:
  - IDLE: tx=1. On transfer, load the shift register and compute parity = ^tx_data (even) or ~^tx_data (odd). Go to START.
  - START: tx=0 for one bit period, then go to DATA with bit counter=0.
  - DATA: tx = shift_reg[0]. At the end of each bit period, shift right and increment the bit counter. After DATA_WIDTH bits, go to PARITY if PARITY!=0, else STOP.
  - PARITY: tx = parity bit for one bit period, then go to STOP.
  - STOP: tx=1 for STOP_BITS bit periods. On the final period's last cycle, pulse frame_done for one cycle and go to IDLE.
- tx is registered (driven from a flop) so it is glitch-free. The start bit appears on tx on the edge after acceptance, i.e. 1 cycle latency.
- busy = (state != IDLE), registered in step with state.
- Back-to-back frames: tx_ready rises on the edge where frame_done pulses. If tx_valid is held high, the next word is accepted on the following edge. Minimum gap between frames is one clk cycle beyond the stop bits.
- Total frame length = (1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS) × CLKS_PER_BIT cycles from the first START cycle to the frame_done cycle inclusive.
- Counter widths: baud counter $clog2(CLKS_PER_BIT), bit counter $clog2(DATA_WIDTH+1). There is no wrap-around beyond the terminal count.
- tx_valid asserted while busy has no effect. The word stays pending with tx_ready=0, and the source must hold it.

Test Plan:
1. Defaults (1 MHz / 9600, CLKS_PER_BIT=104), send 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 104 cycles. frame_done pulses 1040 cycles after the start bit begins. tx_ready=0 throughout.
2. PARITY=1, send 0x07 → parity bit 1. PARITY=2, send 0x07 → parity bit 0. With STOP_BITS=2, the stop phase lasts 208 cycles.
3. Hold tx_valid high with words 0x00 and then 0xFF → the second start bit begins exactly 1 cycle after frame_done. Both frames are bit-exact.
4. Pulse tx_valid with 0x3C while busy mid-frame → ignored. The current frame completes unchanged and no second frame is sent.
5. Assert sreset_n low during DATA bit 3 → on the next edge tx=1, busy=0, tx_ready=1. After release, 0x55 transmits correctly.
6. Loopback into the team's UART receiver with matching parameters, random 256 words → every received word equals the transmitted word.
